// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, forwarding selects and
// multiplier FSM states.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_MUL  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    localparam int MUL_CNT_W = 5;

endpackage

// File: rtl/exec_mul_iter.sv
// Radix-2 shift-add multiplier producing the low word_width bits of a*b.
// Iteration 0 is folded into the start edge so the stage is stalled for
// exactly word_width cycles and the product is presented in DONE.
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int word_width = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [word_width-1:0] a,
    input  logic [word_width-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [word_width-1:0] product
);

    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(word_width - 1);

    mul_state_t              state_r;
    logic [MUL_CNT_W-1:0]    cnt_r;
    logic [word_width-1:0]   acc_r;
    logic [word_width-1:0]   mcand_r;
    logic [word_width-1:0]   mplier_r;

    // FSM, iteration counter and shift-add datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r    <= b[0] ? a : '0;
                        mcand_r  <= {a[word_width-2:0], 1'b0};
                        mplier_r <= {1'b0, b[word_width-1:1]};
                        cnt_r    <= {{(MUL_CNT_W-1){1'b0}}, 1'b1};
                        state_r  <= BUSY;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    acc_r    <= acc_r + (mplier_r[0] ? mcand_r : '0);
                    mcand_r  <= {mcand_r[word_width-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[word_width-1:1]};
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + {{(MUL_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // The start cycle itself must stall, otherwise the mul would leave E
    assign busy    = (state_r == BUSY) | ((state_r == IDLE) & start & ~rst);
    assign done    = (state_r == DONE);
    assign product = acc_r;

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: forwarding muxes, ALU, branch resolution, EX/MEM register.
// Define EXECUTE_MUL_EN to build the iterative multiplier for ALU op 110.
module execute_stage
    import exec_pkg::*;
#(
    parameter int word_width = 32
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic [1:0]            MemWriteE,
    input  logic                  JumpE,
    input  logic                  BranchE,
    input  logic [2:0]            ALUControlE,
    input  logic                  ALUSrcE,
    input  logic [word_width-1:0] RD1E,
    input  logic [word_width-1:0] RD2E,
    input  logic [word_width-1:0] ImmExtE,
    input  logic [4:0]            RdE,
    input  logic [word_width-1:0] PCE,
    input  logic [word_width-1:0] PCPlus4E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [word_width-1:0] ResultW,
    output logic                  PCSrcE,
    output logic [word_width-1:0] PCTargetE,
    output logic                  StallMulE,
    output logic                  RegWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [1:0]            MemWriteM,
    output logic [word_width-1:0] ALUResultM,
    output logic [word_width-1:0] WriteDataM,
    output logic [word_width-1:0] PCPlus4M,
    output logic [4:0]            RdM
);

    logic [word_width-1:0] src_a_s;
    logic [word_width-1:0] write_data_s;
    logic [word_width-1:0] src_b_s;
    logic [word_width-1:0] alu_result_s;
    logic [word_width-1:0] mul_result_s;
    logic                  zero_s;
    logic                  stall_s;

    function automatic logic [word_width-1:0] fwd_pick(
        input logic [1:0]            sel,
        input logic [word_width-1:0] reg_val,
        input logic [word_width-1:0] w_val,
        input logic [word_width-1:0] m_val
    );
        logic [word_width-1:0] r;
        case (sel)
            FWD_W:   r = w_val;
            FWD_M:   r = m_val;
            default: r = reg_val;
        endcase
        return r;
    endfunction

    assign src_a_s      = fwd_pick(ForwardAE, RD1E, ResultW, ALUResultM);
    assign write_data_s = fwd_pick(ForwardBE, RD2E, ResultW, ALUResultM);
    assign src_b_s      = ALUSrcE ? ImmExtE : write_data_s;

`ifdef EXECUTE_MUL_EN
    logic                  mul_start_s;
    logic                  mul_done_s;
    logic [word_width-1:0] mul_product_s;

    assign mul_start_s = (ALUControlE == ALU_MUL);

    exec_mul_iter #(.word_width(word_width)) u_mul (
        .clk     (clk),
        .rst     (reset),
        .start   (mul_start_s),
        .a       (src_a_s),
        .b       (src_b_s),
        .busy    (stall_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    assign mul_result_s = mul_done_s ? mul_product_s : '0;
`else
    assign stall_s      = 1'b0;
    assign mul_result_s = '0;
`endif

    // ALU operation select
    always_comb begin
        alu_result_s = '0;
        case (ALUControlE)
            ALU_ADD:  alu_result_s = src_a_s + src_b_s;
            ALU_SUB:  alu_result_s = src_a_s - src_b_s;
            ALU_AND:  alu_result_s = src_a_s & src_b_s;
            ALU_OR:   alu_result_s = src_a_s | src_b_s;
            ALU_XOR:  alu_result_s = src_a_s ^ src_b_s;
            ALU_SLT:  alu_result_s = {{(word_width-1){1'b0}},
                                      ($signed(src_a_s) < $signed(src_b_s))};
            ALU_SLTU: alu_result_s = {{(word_width-1){1'b0}}, (src_a_s < src_b_s)};
            ALU_MUL:  alu_result_s = mul_result_s;
            default:  alu_result_s = '0;
        endcase
    end

    assign zero_s    = (alu_result_s == '0);
    assign PCSrcE    = (BranchE & zero_s) | JumpE;
    assign PCTargetE = PCE + ImmExtE;
    assign StallMulE = stall_s;

    // EX/MEM pipeline register; a stalled edge inserts an all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            MemWriteM  <= 2'b00;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= 5'd0;
        end else if (stall_s) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            MemWriteM  <= 2'b00;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= 5'd0;
        end else begin
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
            ALUResultM <= alu_result_s;
            WriteDataM <= write_data_s;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized
// traffic against a plain-arithmetic reference model.
module tb_execute_stage;

    localparam int W = 32;
`ifdef EXECUTE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]    ResultSrcE, MemWriteE, ForwardAE, ForwardBE;
    logic [2:0]    ALUControlE;
    logic [W-1:0]  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]    RdE;
    logic          PCSrcE, StallMulE, RegWriteM;
    logic [W-1:0]  PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]    ResultSrcM, MemWriteM;
    logic [4:0]    RdM;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_alu_m = '0;

    execute_stage #(.word_width(W)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallMulE(StallMulE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU from the instruction-set meaning of each opcode
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint signed sa = longint'($signed(a));
        longint signed sb = longint'($signed(b));
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        case (op)
            3'd0:    return W'(ua + ub);
            3'd1:    return W'(ua - ub);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd7:    return (ua < ub) ? 32'd1 : 32'd0;
            default: return MUL_ON ? W'(ua * ub) : 32'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_fwd(input logic [1:0] sel, input logic [W-1:0] r,
                                             input logic [W-1:0] w, input logic [W-1:0] m);
        if (sel == 2'b01) return w;
        else if (sel == 2'b10) return m;
        else return r;
    endfunction

    task automatic drive_idle();
        RegWriteE = 1'b0; ResultSrcE = 2'b00; MemWriteE = 2'b00; JumpE = 1'b0;
        BranchE = 1'b0; ALUControlE = 3'd0; ALUSrcE = 1'b0; RD1E = '0; RD2E = '0;
        ImmExtE = '0; RdE = 5'd0; PCE = '0; PCPlus4E = '0; ForwardAE = 2'b00;
        ForwardBE = 2'b00; ResultW = '0;
    endtask

    // One single-cycle instruction through E, checked against the model
    task automatic issue(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                         input logic alusrc, input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                         input logic [W-1:0] imm, input logic [W-1:0] resw,
                         input logic [W-1:0] pce, input logic br, input logic jp);
        logic [W-1:0] a, wd, res;
        logic rw;
        logic [1:0] rs, mw;
        logic [4:0] rd;
        rw = 1'($urandom_range(0, 1)); rs = 2'($urandom_range(0, 3));
        mw = 2'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
        ALUControlE = op; ForwardAE = fa; ForwardBE = fb; ALUSrcE = alusrc;
        RD1E = rd1; RD2E = rd2; ImmExtE = imm; ResultW = resw; PCE = pce;
        PCPlus4E = pce + 32'd4; BranchE = br; JumpE = jp;
        RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; RdE = rd;
        a   = ref_fwd(fa, rd1, resw, exp_alu_m);
        wd  = ref_fwd(fb, rd2, resw, exp_alu_m);
        res = ref_alu(op, a, alusrc ? imm : wd);
        #1;
        check_val("pcsrc", 32'(PCSrcE), 32'((br && res == 32'd0) || jp));
        check_val("pctarget", PCTargetE, pce + imm);
        check_val("stall", 32'(StallMulE), 32'd0);
        tick();
        check_val("alu_m", ALUResultM, res);
        check_val("wdata_m", WriteDataM, wd);
        check_val("regwr_m", 32'(RegWriteM), 32'(rw));
        check_val("ressrc_m", 32'(ResultSrcM), 32'(rs));
        check_val("memwr_m", 32'(MemWriteM), 32'(mw));
        check_val("rd_m", 32'(RdM), 32'(rd));
        check_val("pc4_m", PCPlus4M, pce + 32'd4);
        exp_alu_m = res;
    endtask

    // Wait out a multiply already presented in E, then check its result
    task automatic mul_wait(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        longint unsigned prod;
        n = 0;
        while (StallMulE === 1'b1 && n < 100) begin
            n++;
            tick();
            check_val({tag, "_bubble_rw"}, 32'(RegWriteM), 32'd0);
        end
        check_val({tag, "_stall_cycles"}, 32'(n), 32'd32);
        tick();
        prod = longint'(a) * longint'(b);
        check_val({tag, "_product"}, ALUResultM, W'(prod));
        check_val({tag, "_rw"}, 32'(RegWriteM), 32'd1);
        exp_alu_m = W'(prod);
    endtask

    task automatic mul_present(input logic [W-1:0] a, input logic [W-1:0] b);
        drive_idle();
        ALUControlE = 3'b110; RD1E = a; RD2E = b; RegWriteE = 1'b1; RdE = 5'd9;
    endtask

    initial begin
        logic [2:0] op;
        logic [W-1:0] r1, r2;
        reset = 1'b1;
        drive_idle();
        #12;
        check_val("rst_regwr", 32'(RegWriteM), 32'd0);
        check_val("rst_alu", ALUResultM, 32'd0);
        check_val("rst_rd", 32'(RdM), 32'd0);
        check_val("rst_pc4", PCPlus4M, 32'd0);
        check_val("rst_stall", 32'(StallMulE), 32'd0);
        reset = 1'b0;
        tick();

        // Forwarding from M and from W
        issue(3'd0, 2'b00, 2'b00, 1'b1, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(3'd0, 2'b10, 2'b00, 1'b1, 32'd5, 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        check_val("fwd_m_const", ALUResultM, 32'd103);
        issue(3'd0, 2'b01, 2'b00, 1'b1, 32'd5, 32'd0, 32'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        check_val("fwd_w_const", ALUResultM, 32'd10);

        // Branch taken / not taken
        issue(3'd1, 2'b00, 2'b00, 1'b0, 32'h20, 32'h20, 32'hFFFF_FFF8, 32'd0, 32'h100, 1'b1, 1'b0);
        check_val("beq_taken", 32'(PCSrcE), 32'd1);
        check_val("beq_target", PCTargetE, 32'h0000_00F8);
        issue(3'd1, 2'b00, 2'b00, 1'b0, 32'h20, 32'h21, 32'hFFFF_FFF8, 32'd0, 32'h100, 1'b1, 1'b0);
        check_val("beq_not_taken", 32'(PCSrcE), 32'd0);

        // Signed vs unsigned compare and add wraparound
        issue(3'd5, 2'b00, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        check_val("slt_const", ALUResultM, 32'd1);
        issue(3'd7, 2'b00, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        check_val("sltu_const", ALUResultM, 32'd0);
        issue(3'd0, 2'b00, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        check_val("add_wrap_const", ALUResultM, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            if (MUL_ON && op == 3'b110) op = 3'd0;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), r1, r2, $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        if (MUL_ON) begin
            mul_present(32'd7, 32'hFFFF_FFFD);
            #1;
            mul_wait("mul_plan", 32'd7, 32'hFFFF_FFFD);
            check_val("mul_plan_const", ALUResultM, 32'hFFFF_FFEB);
            for (int k = 0; k < 3; k++) begin
                r1 = $urandom; r2 = $urandom;
                mul_present(r1, r2);
                #1;
                mul_wait("mul_rand", r1, r2);
            end
            // Reset in the middle of a multiply
            mul_present(32'd7, 32'd3);
            #1;
            for (int k = 0; k < 10; k++) tick();
            check_val("mid_stall_before", 32'(StallMulE), 32'd1);
            #2 reset = 1'b1;
            #1;
            check_val("mid_rst_stall", 32'(StallMulE), 32'd0);
            check_val("mid_rst_regwr", 32'(RegWriteM), 32'd0);
            check_val("mid_rst_alu", ALUResultM, 32'd0);
            check_val("mid_rst_memwr", 32'(MemWriteM), 32'd0);
            check_val("mid_rst_rd", 32'(RdM), 32'd0);
            exp_alu_m = '0;
            #2 reset = 1'b0;
            #1;
            mul_wait("mul_after_rst", 32'd7, 32'd3);
            check_val("mul_after_rst_const", ALUResultM, 32'd21);
        end else begin
            issue(3'b110, 2'b00, 2'b00, 1'b0, 32'd7, 32'd3, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            check_val("nomul_alu", ALUResultM, 32'd0);
            for (int k = 0; k < 3; k++) begin
                tick();
                check_val("nomul_stall", 32'(StallMulE), 32'd0);
            end
        end

        drive_idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RISC-V 5-stage execute stage; consumes the ID/EX register outputs (*E signals) and produces the EX/MEM pipeline register (*M signals).
- Contains the forwarding muxes, ALU, branch/jump resolution (PCSrcE, PCTargetE) and EX/MEM register.
- Optionally contains an iterative multiplier that stalls the front end while busy.

Parameters:
- word_width, 32, datapath width in bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- RegWriteE  in  1  register-file write enable
- ResultSrcE  in  2  writeback source select
- MemWriteE  in  2  store enable/size code
- JumpE  in  1  jal/jalr in E
- BranchE  in  1  beq in E
- ALUControlE  in  3  ALU op
- ALUSrcE  in  1  0: SrcB=forwarded RD2; 1: SrcB=ImmExtE
- RD1E, RD2E, ImmExtE  in  word_width each  operands
- RdE  in  5  destination register
- PCE, PCPlus4E  in  word_width each  PC values
- ForwardAE, ForwardBE  in  2 each  00: RD1E/RD2E; 01: ResultW; 10: ALUResultM; 11: same as 00
- ResultW  in  word_width  writeback-stage result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  word_width  PCE+ImmExtE (combinational)
- StallMulE  out  1  multiplier busy; hazard unit stalls F/D/E (combinational from state)
- RegWriteM  out  1
- ResultSrcM  out  2
- MemWriteM  out  2
- ALUResultM, WriteDataM, PCPlus4M  out  word_width each
- RdM  out  5

Behaviour:
- Reset (asynchronous): all *M outputs, multiplier counter and state cleared to 0; StallMulE=0.
- SrcAE = ForwardAE mux. WriteDataE = ForwardBE mux. SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALUControlE: 000 add; 001 sub; 010 and; 011 or; 100 xor; 101 slt (signed, result 1/0); 111 sltu; 110 mul (see optional feature). All arithmetic wraps modulo 2^word_width.
- ZeroE = (ALUResult==0). PCSrcE = (BranchE & ZeroE) | JumpE.
- PCTargetE = PCE + ImmExtE. jalr target formation is outside this block.
- EX/MEM register: one-cycle latency. Every rising edge captures the E values: ALUResultM<=ALUResult, WriteDataM<=WriteDataE, RdM, PCPlus4M, RegWriteM, ResultSrcM, MemWriteM.
- While StallMulE=1, the edge captures a bubble: RegWriteM=0, MemWriteM=0. Data fields are don't-care but are driven 0.
- The block has no flush input; E-stage flushing is done upstream in the ID/EX register.

Optional Feature:
- Macro: EXECUTE_MUL_EN.
- With EXECUTE_MUL_EN, op 110 is a radix-2 shift-add multiply producing the low word_width bits of the product, using an FSM with states IDLE, BUSY, DONE:
  - IDLE: op 110 in E enters BUSY at cycle t and latches operands; StallMulE=1.
  - BUSY: one iteration per cycle; a 5-bit counter runs 0..word_width-1; StallMulE=1 throughout. Operand latches ignore E inputs, because E is held by the stall.
  - DONE: entered after the final iteration at cycle t+word_width; StallMulE=0. On that edge EX/MEM captures the product with RegWriteM=RegWriteE; next state is IDLE.
  - Total occupancy of E: word_width+1 cycles. Back-to-back muls restart from IDLE.
  - Reset mid-operation returns to IDLE with counter and partial product cleared.
- Without EXECUTE_MUL_EN: op 110 yields ALUResult=0, StallMulE is tied 0, and no multiplier logic is generated.

Decomposition:
- Shared package exec_pkg holds:
  - alu_op_t enum: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_MUL, ALU_SLTU.
  - fwd_sel_t enum: FWD_REG=00, FWD_W=01, FWD_M=10.
  - mul_state_t enum: IDLE, BUSY, DONE.
- One natural sub-module: exec_mul_iter (FSM, counter, shift-add datapath; ports start, a, b, busy, done, product). It is instantiated only under EXECUTE_MUL_EN.

Test Plan:
- Forwarding: RD1E=5, ALUResultM=100, ForwardAE=10, ImmExtE=3, ALUSrcE=1, op add -> next-cycle ALUResultM=103. Same with ForwardAE=01, ResultW=7 -> 10.
- Branch: BranchE=1, op sub, RD1E=RD2E=0x20, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8. With RD2E=0x21 -> PCSrcE=0.
- slt vs sltu: SrcA=0xFFFFFFFF, SrcB=1 -> slt result 1, sltu result 0. add 0xFFFFFFFF+1 -> 0.
- Multiply (macro on): RD1E=7, RD2E=0xFFFFFFFD, op 110 -> StallMulE high 32 cycles, RegWriteM=0 during stall, then ALUResultM=0xFFFFFFEB with RegWriteM=1 exactly one cycle later.
- Reset mid-multiply: assert reset at iteration 10 -> StallMulE=0 and all *M outputs=0 immediately. A following mul completes in a full 33 cycles.
- Macro off: op 110 with RD1E=7, RD2E=3 -> ALUResultM=0, StallMulE never asserted.
